contador_4bits_up: RTL and testbench

Sequential 4-bit up counter that consumes the 4-bit code produced by the counter-select encoder stage and uses it as the terminal count. A start edge latches the code, the counter advances once per prescaled tick from 0 to the latched limit, then holds and flags completion. It sits directly downstream of the encoder and drives the display/indicator logic.

---
 rtl/contador_4bits_up_pkg.sv | 13 +
 rtl/contador_4bits_up_prescaler_tick.sv | 29 ++
 rtl/contador_4bits_up.sv | 82 ++++++++
 tb/tb_contador_4bits_up.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_4bits_up_pkg.sv
// Shared state encoding and count width for the terminal-count up counter.
package contador_4bits_up_pkg;

  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/contador_4bits_up_prescaler_tick.sv
// Divides the system clock into one-cycle count ticks; freezes when not enabled.
module prescaler_tick #(
  parameter int CLK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;

  // Tick is only meaningful while enabled, so a frozen prescaler never fires.
  assign tick = enable & (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre_cnt <= '0;
    end else if (enable) begin
      if (tick) pre_cnt <= '0;
      else      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/contador_4bits_up.sv
// 4-bit up counter: counts prescaled ticks from 0 to a start-latched limit, then holds.
module contador_4bits_up
  import contador_4bits_up_pkg::*;
#(
  parameter int CLK_DIV = 50000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] limit,
  input  logic               start,
  input  logic               pause,
  output logic [COUNT_W-1:0] count,
  output logic               running,
  output logic               done
);

  state_t             state, state_nxt;
  logic [COUNT_W-1:0] count_nxt;
  logic [COUNT_W-1:0] limit_q, limit_nxt;
  logic               start_q;
  logic               start_rise;
  logic               pre_en;
  logic               tick;

  assign start_rise = start & ~start_q;
  // The prescaler advances only in an uninterrupted RUN cycle, so pause freezes the partial interval.
  assign pre_en     = (state == ST_RUN) & ~pause & ~start_rise;

  prescaler_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (start_rise),
    .enable(pre_en),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    limit_nxt = limit_q;
    if (start_rise) begin
      limit_nxt = limit;
      count_nxt = '0;
      state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (pause) begin
            state_nxt = ST_HOLD;
          end else if (tick) begin
            if (count == limit_q) state_nxt = ST_DONE;
            else                  count_nxt = count + COUNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (!pause) state_nxt = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      limit_q <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      limit_q <= limit_nxt;
      start_q <= start;
    end
  end

  assign running = (state == ST_RUN);
  assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_contador_4bits_up.sv
// Directed bench for contador_4bits_up with CLK_DIV=4; inputs driven and outputs sampled on falling edges.
module tb_contador_4bits_up;

  logic       clk;
  logic       reset;
  logic [3:0] limit;
  logic       start;
  logic       pause;
  logic [3:0] count;
  logic       running;
  logic       done;

  int n_tests;
  int n_fail;

  contador_4bits_up #(
    .CLK_DIV(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .limit  (limit),
    .start  (start),
    .pause  (pause),
    .count  (count),
    .running(running),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge N is the first rising edge after start is raised; waits below are counted from it.
  task automatic test_reset();
    reset = 1'b1; limit = 4'd9; start = 1'b1; pause = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got r=%0b d=%0b c=%0d, want r=0 d=0 c=0", running, done, count);
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_release_idle: got r=%0b d=%0b c=%0d, want r=0 d=0 c=0", running, done, count);
    end
  endtask

  task automatic test_basic_count();
    limit = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if ({running, done, count} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL basic_start: got r=%0b d=%0b c=%0d, want r=1 d=0 c=0", running, done, count);
    end
    for (int k = 1; k <= 3; k++) begin
      repeat (4) @(negedge clk);
      n_tests++;
      if ({running, done, count} !== {1'b1, 1'b0, 4'(k)}) begin
        n_fail++;
        $display("FAIL basic_step%0d: got r=%0b d=%0b c=%0d, want r=1 d=0 c=%0d", k, running, done, count, k);
      end
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b1, 1'b0, 4'd3}) begin
      n_fail++;
      $display("FAIL basic_pre_done: got r=%0b d=%0b c=%0d, want r=1 d=0 c=3", running, done, count);
    end
    @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b1, 4'd3}) begin
      n_fail++;
      $display("FAIL basic_done16: got r=%0b d=%0b c=%0d, want r=0 d=1 c=3", running, done, count);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b1, 4'd3}) begin
      n_fail++;
      $display("FAIL basic_done_hold: got r=%0b d=%0b c=%0d, want r=0 d=1 c=3", running, done, count);
    end
  endtask

  // Pause is high before edges N+10..N+15; HOLD->RUN at N+16 costs one more frozen cycle,
  // so every later event shifts by 7 cycles: count 3 at N+19, done at N+31.
  task automatic test_pause();
    limit = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b1, 1'b0, 4'd2}) begin
      n_fail++;
      $display("FAIL pause_before: got r=%0b d=%0b c=%0d, want r=1 d=0 c=2", running, done, count);
    end
    @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b0, 4'd2}) begin
      n_fail++;
      $display("FAIL pause_hold_entry: got r=%0b d=%0b c=%0d, want r=0 d=0 c=2", running, done, count);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b0, 4'd2}) begin
      n_fail++;
      $display("FAIL pause_frozen: got r=%0b d=%0b c=%0d, want r=0 d=0 c=2", running, done, count);
    end
    pause = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b1, 1'b0, 4'd2}) begin
      n_fail++;
      $display("FAIL pause_partial: got r=%0b d=%0b c=%0d, want r=1 d=0 c=2", running, done, count);
    end
    @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b1, 1'b0, 4'd3}) begin
      n_fail++;
      $display("FAIL pause_resume_tick: got r=%0b d=%0b c=%0d, want r=1 d=0 c=3", running, done, count);
    end
    repeat (11) @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b1, 1'b0, 4'd5}) begin
      n_fail++;
      $display("FAIL pause_pre_done: got r=%0b d=%0b c=%0d, want r=1 d=0 c=5", running, done, count);
    end
    @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b1, 4'd5}) begin
      n_fail++;
      $display("FAIL pause_done: got r=%0b d=%0b c=%0d, want r=0 d=1 c=5", running, done, count);
    end
  endtask

  task automatic test_start_held();
    limit = 4'd7; start = 1'b1;
    @(negedge clk);
    limit = 4'd1;
    n_tests++;
    if ({running, done, count} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL held_start: got r=%0b d=%0b c=%0d, want r=1 d=0 c=0", running, done, count);
    end
    repeat (19) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b1, 1'b0, 4'd5}) begin
      n_fail++;
      $display("FAIL held_no_restart: got r=%0b d=%0b c=%0d, want r=1 d=0 c=5", running, done, count);
    end
    repeat (8) @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b1, 1'b0, 4'd7}) begin
      n_fail++;
      $display("FAIL held_count7: got r=%0b d=%0b c=%0d, want r=1 d=0 c=7", running, done, count);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b1, 4'd7}) begin
      n_fail++;
      $display("FAIL held_done: got r=%0b d=%0b c=%0d, want r=0 d=1 c=7", running, done, count);
    end
  endtask

  task automatic test_back_to_back();
    limit = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b1, 1'b0, 4'd4}) begin
      n_fail++;
      $display("FAIL b2b_count4: got r=%0b d=%0b c=%0d, want r=1 d=0 c=4", running, done, count);
    end
    limit = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; limit = 4'd9;
    n_tests++;
    if ({running, done, count} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL b2b_restart: got r=%0b d=%0b c=%0d, want r=1 d=0 c=0", running, done, count);
    end
    repeat (8) @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b1, 1'b0, 4'd2}) begin
      n_fail++;
      $display("FAIL b2b_count2: got r=%0b d=%0b c=%0d, want r=1 d=0 c=2", running, done, count);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b1, 4'd2}) begin
      n_fail++;
      $display("FAIL b2b_resampled_done: got r=%0b d=%0b c=%0d, want r=0 d=1 c=2", running, done, count);
    end
  endtask

  task automatic test_limit_zero();
    limit = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL zero_pre_done: got r=%0b d=%0b c=%0d, want r=1 d=0 c=0", running, done, count);
    end
    @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL zero_done4: got r=%0b d=%0b c=%0d, want r=0 d=1 c=0", running, done, count);
    end
    pause = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL zero_done_pause: got r=%0b d=%0b c=%0d, want r=0 d=1 c=0", running, done, count);
    end
    pause = 1'b0;
  endtask

  task automatic test_reset_hold_done();
    limit = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL rst_hold_entry: got r=%0b d=%0b c=%0d, want r=0 d=0 c=1", running, done, count);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL rst_from_hold: got r=%0b d=%0b c=%0d, want r=0 d=0 c=0", running, done, count);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL idle_pause_ignored: got r=%0b d=%0b c=%0d, want r=0 d=0 c=0", running, done, count);
    end
    pause = 1'b0; limit = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL rst_done_entry: got r=%0b d=%0b c=%0d, want r=0 d=1 c=1", running, done, count);
    end
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL rst_from_done: got r=%0b d=%0b c=%0d, want r=0 d=0 c=0", running, done, count);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({running, done, count} !== {1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL rst_done_after: got r=%0b d=%0b c=%0d, want r=0 d=0 c=0", running, done, count);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; limit = 4'd0; start = 1'b0; pause = 1'b0;
    test_reset();
    test_basic_count();
    test_pause();
    test_start_held();
    test_back_to_back();
    test_limit_zero();
    test_reset_hold_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
